grf_sb: RTL

Parametrised general register file with two read ports and two write ports. It adds write-to-read bypass from both write ports and a per-register pending-write scoreboard for hazard detection. It sits in the decode/writeback stage of the pipelined CPU: it replaces the single-write-port GRF and gives the hazard unit its busy/stall information directly.

---
 rtl/grf_sb.sv | 108 ++++++++++
 1 files changed

// File: rtl/grf_sb.sv
// Two-read/two-write register file with write bypass and a pending-write scoreboard; GRF_TRACE_EN prints committed writes.
// Latency: reads are combinational (bypass 0 cycles, stored value 1 cycle after the write edge); pend_cnt is registered.
// Backpressure: none; busy1/busy2/waw are advisory outputs for the hazard unit, which owns any stall.
module grf_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              iss_v,
    input  logic [ADDR_W-1:0] iss_a,
    output logic              busy1,
    output logic              busy2,
    output logic              waw,
    output logic [ADDR_W:0]   pend_cnt,
    input  logic [31:0]       pc
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_nxt;
    logic [DEPTH-1:0]  hitv;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_nxt;
    logic              wen0;
    logic              wen1;

    // Writes aimed at a hardwired zero register never commit and never clear pending state.
    assign wen0 = we0 && !((ZERO_REG != 0) && (wa0 == '0));
    assign wen1 = we1 && !((ZERO_REG != 0) && (wa1 == '0));

    always_comb begin
        hitv        = '0;
        pending_nxt = pending;
        cnt_nxt     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hitv[i] = (wen0 && (wa0 == ADDR_W'(i))) || (wen1 && (wa1 == ADDR_W'(i)));
            // A new issue outranks a completing write to the same register.
            if (iss_v && (iss_a == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0)))
                pending_nxt[i] = 1'b1;
            else if (hitv[i])
                pending_nxt[i] = 1'b0;
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(pending_nxt[i]);
        end
    end

    function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
        if (reset || ((ZERO_REG != 0) && (a == '0)))
            return '0;
        else if (we1 && (wa1 == a))
            return wd1;
        else if (we0 && (wa0 == a))
            return wd0;
        else
            return regs[a];
    endfunction

    assign rd1      = rd_port(a1);
    assign rd2      = rd_port(a2);
    assign busy1    = !reset && pending[a1] && !hitv[a1];
    assign busy2    = !reset && pending[a2] && !hitv[a2];
    assign waw      = !reset && iss_v && pending[iss_a] && !hitv[iss_a];
    assign pend_cnt = cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else begin
            pending <= pending_nxt;
            cnt_q   <= cnt_nxt;
            if (wen0)
                regs[wa0] <= wd0;
            if (wen1)
                regs[wa1] <= wd1;
        end
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wen0 && !(wen1 && (wa1 == wa0)))
                $display("%0t@%h: $%0d <= %h", $time, pc, wa0, wd0);
            if (wen1)
                $display("%0t@%h: $%0d <= %h", $time, pc, wa1, wd1);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule
